// File: rtl/data_memory_responder.sv
// Data-memory responder for the MEM stage: accepts one load/store at a time,
// models a multi-cycle RAM, handles RV32I byte/half/word lanes and load
// extension, and stalls the pipeline while an access is outstanding.
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  access_error,
  output logic                  stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t state, next_state;
  logic [3:0] count, next_count;

  // Captured request (only the address bits that select a word/lane are kept).
  logic                  cap_write;
  logic [ADDR_WIDTH+1:0] cap_addr;
  logic [31:0]           cap_wdata;
  logic [2:0]            cap_funct3;

  // Access being completed on this edge: straight from the inputs when the
  // access goes IDLE->RESP with no wait states, otherwise from the capture.
  logic                  acc_write;
  logic [ADDR_WIDTH+1:0] acc_addr;
  logic [31:0]           acc_wdata;
  logic [2:0]            acc_funct3;
  logic [ADDR_WIDTH-1:0] acc_index;
  logic                  acc_error;
  logic                  commit;
  logic [31:0]           old_word;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Upper address bits alias onto the array and are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  // Misaligned half/word accesses and illegal funct3 encodings.
  function automatic logic is_error(input logic wr, input logic [2:0] f3, input logic [1:0] a);
    logic e;
    e = 1'b0;
    case (f3[1:0])
      2'b01:   e = a[0];
      2'b10:   e = (a != 2'b00);
      default: e = 1'b0;
    endcase
    if (wr) begin
      if (f3[2] || (f3[1:0] == 2'b11)) e = 1'b1;
      else e = e;
    end else begin
      if ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)) e = 1'b1;
      else e = e;
    end
    return e;
  endfunction

  // Merge right-aligned store data into the selected lanes of the old word.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] m;
    m = old;
    case (f3[1:0])
      2'b00:   m[{a, 3'b000} +: 8] = wd[7:0];
      2'b01:   m[{a[1], 4'b0000} +: 16] = wd[15:0];
      2'b10:   m = wd;
      default: m = old;
    endcase
    return m;
  endfunction

  // Select the addressed byte/half and sign- or zero-extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = w;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign req_ready = (state == IDLE);
  assign stall     = ((state == IDLE) && req_valid) || (state == BUSY);

  assign acc_write  = (state == IDLE) ? req_write : cap_write;
  assign acc_addr   = (state == IDLE) ? req_addr[ADDR_WIDTH+1:0] : cap_addr;
  assign acc_wdata  = (state == IDLE) ? req_wdata : cap_wdata;
  assign acc_funct3 = (state == IDLE) ? req_funct3 : cap_funct3;
  assign acc_index  = acc_addr[ADDR_WIDTH+1:2];
  assign acc_error  = is_error(acc_write, acc_funct3, acc_addr[1:0]);
  assign old_word   = mem[acc_index];
  assign commit     = (state != RESP) && (next_state == RESP);

  // Next-state and wait-counter logic.
  always_comb begin
    next_state = state;
    next_count = count;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            next_state = RESP;
          end else begin
            next_state = BUSY;
            next_count = WAIT_LOAD;
          end
        end else begin
          next_state = IDLE;
        end
      end
      BUSY: begin
        if (count == 4'd0) begin
          next_state = RESP;
        end else begin
          next_count = count - 4'd1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, request capture and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= 4'd0;
      cap_write    <= 1'b0;
      cap_addr     <= '0;
      cap_wdata    <= 32'd0;
      cap_funct3   <= 3'd0;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'd0;
      access_error <= 1'b0;
    end else begin
      state <= next_state;
      count <= next_count;
      if ((state == IDLE) && req_valid) begin
        cap_write  <= req_write;
        cap_addr   <= req_addr[ADDR_WIDTH+1:0];
        cap_wdata  <= req_wdata;
        cap_funct3 <= req_funct3;
      end
      resp_valid   <= commit;
      access_error <= commit && acc_error;
      resp_rdata   <= (commit && !acc_error && !acc_write)
                      ? load_extract(old_word, acc_funct3, acc_addr[1:0]) : 32'd0;
    end
  end

  // Store commit on the edge entering RESP; suppressed by reset and errors.
  always_ff @(posedge clk) begin
    if (!reset && commit && acc_write && !acc_error) begin
      mem[acc_index] <= store_merge(old_word, acc_wdata, acc_funct3, acc_addr[1:0]);
    end
  end

endmodule
